multi_channel_timer: RTL

// - Parametrised Avalon-MM interval timer, NUM_CH independent down-counters of CNT_W bits.
// - Memory-mapped slave on the Nios II system bus; drives game-tick, paddle-sample and

---
 rtl/multi_channel_timer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: Avalon-MM interval timer with NUM_CH independent down-counters.
// Optional per-channel 8-bit prescaler is enabled by defining MULTI_CHANNEL_TIMER_PRESCALE_EN.
module multi_channel_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999,
  localparam int AW            = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_PERIOD);

  logic [AW-1:0] addr_ch;
  logic [1:0]    reg_sel;
  logic          wr_en;
  logic [31:0]   rd_word [NUM_CH];
  logic [31:0]   rd_next;
  logic          unused_wd;

  assign addr_ch   = address >> 2;
  assign reg_sel   = address[1:0];
  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             sel;
    logic             wr_status;
    logic             wr_ctrl;
    logic             wr_period;
    logic             wr_snap;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] snap;
    logic             to;
    logic             run;
    logic             ito;
    logic             cont;
    logic [7:0]       presc;
    logic             tick;
    logic             timeout;

    assign sel       = wr_en && (addr_ch == AW'(c));
    assign wr_status = sel && (reg_sel == 2'd0);
    assign wr_ctrl   = sel && (reg_sel == 2'd1);
    assign wr_period = sel && (reg_sel == 2'd2);
    assign wr_snap   = sel && (reg_sel == 2'd3);

`ifdef MULTI_CHANNEL_TIMER_PRESCALE_EN
    logic [7:0] pcnt;

    assign tick = run && (pcnt == presc);

    // Any CONTROL write (START, STOP or PRESC) or PERIOD write realigns the prescaler.
    always_ff @(posedge clk) begin
      if (reset) begin
        presc <= '0;
        pcnt  <= '0;
      end else begin
        if (wr_ctrl)
          presc <= writedata[15:8];
        if (wr_ctrl || wr_period)
          pcnt <= '0;
        else if (tick)
          pcnt <= '0;
        else if (run)
          pcnt <= pcnt + 8'd1;
      end
    end
`else
    assign presc = '0;
    assign tick  = run;
`endif

    assign timeout = tick && (cnt == '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= PERIOD_RST;
        period <= PERIOD_RST;
        snap   <= '0;
        to     <= 1'b0;
        run    <= 1'b0;
        ito    <= 1'b0;
        cont   <= 1'b0;
      end else begin
        if (wr_period) begin
          period <= writedata[CNT_W-1:0];
          cnt    <= writedata[CNT_W-1:0];
        end else if (tick) begin
          cnt <= (cnt == '0) ? period : cnt - CNT_W'(1);
        end

        // STOP beats START; an explicit write beats the one-shot auto-stop.
        if (wr_period)
          run <= 1'b0;
        else if (wr_ctrl && writedata[3])
          run <= 1'b0;
        else if (wr_ctrl && writedata[2])
          run <= 1'b1;
        else if (timeout)
          run <= cont;

        if (timeout)
          to <= 1'b1;
        else if (wr_status)
          to <= 1'b0;

        if (wr_ctrl) begin
          ito  <= writedata[0];
          cont <= writedata[1];
        end

        if (wr_snap)
          snap <= cnt;
      end
    end

    assign rd_word[c] = (reg_sel == 2'd0) ? {30'd0, run, to} :
                        (reg_sel == 2'd1) ? {16'd0, presc, 6'd0, cont, ito} :
                        (reg_sel == 2'd2) ? 32'(period) :
                                            32'(snap);

    assign irq_vec[c] = to & ito;
  end

  assign irq = |irq_vec;

  // Out-of-range channels match no entry and read back as zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (addr_ch == AW'(i))
        rd_next = rd_word[i];
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

endmodule
